// File: rtl/lcg_rng_fifo_if.sv
// Output handshake bundle for lcg_rng_fifo: the generator drives the head word
// and its valid flag, the consumer drives ready.
interface lcg_rng_fifo_if #(
  parameter int OUT_W = 16
) ();
  logic             rand_valid;
  logic             rand_ready;
  logic [OUT_W-1:0] rand_out;

  modport master (
    output rand_valid,
    output rand_out,
    input  rand_ready
  );

  modport slave (
    input  rand_valid,
    input  rand_out,
    output rand_ready
  );
endinterface

// File: rtl/lcg_rng_fifo.sv
// Parametrised LCG random-word source with runtime reseeding, a run-ahead
// circular output FIFO, valid/ready back-pressure and period-wrap detection.
module lcg_rng_fifo #(
  parameter int                 STATE_W = 32,
  parameter int                 OUT_W   = 16,
  parameter logic [STATE_W-1:0] MULT    = STATE_W'(1664525),
  parameter logic [STATE_W-1:0] INC     = STATE_W'(1013904223),
  parameter logic [STATE_W-1:0] SEED    = STATE_W'(1),
  parameter int                 DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   seed_load,
  input  logic [STATE_W-1:0]     seed_in,
  lcg_rng_fifo_if.master         rand_bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   period_wrap
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] anchor;
  logic [STATE_W-1:0] next_state;
  logic [OUT_W-1:0]   sample;
  logic [OUT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic               wrap_q;
  logic               pop;
  logic               step;
  logic               not_empty;

  // Modular arithmetic falls out of the STATE_W-wide operands.
  assign next_state = state * MULT + INC;
  assign sample     = next_state[STATE_W-1 -: OUT_W];

  assign not_empty = (level_q != '0);
  assign pop       = not_empty & rand_bus.rand_ready;
  // A full FIFO may still step when the head leaves in the same cycle.
  assign step      = en & ~seed_load & ((level_q < FULL_LVL) | pop);

  assign rand_bus.rand_valid = not_empty;
  assign rand_bus.rand_out   = not_empty ? mem[rd_ptr] : '0;
  assign level               = level_q;
  assign period_wrap         = wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SEED;
      anchor  <= SEED;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      wrap_q  <= 1'b0;
    end else if (seed_load) begin
      state   <= seed_in;
      anchor  <= seed_in;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      if (step) begin
        state  <= next_state;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({step, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      wrap_q <= step & (next_state == anchor);
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && !seed_load && step) begin
      mem[wr_ptr] <= sample;
    end
  end

endmodule

// File: tb/tb_lcg_rng_fifo.sv
// Directed bench for lcg_rng_fifo: a 16/8-bit instance for sequence, back-pressure,
// reseed and reset, plus a 4-bit full-period instance for wrap detection.
module tb_lcg_rng_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        enA;
   logic        seedLoadA;
   logic [15:0] seedInA;
   logic [2:0]  levelA;
   logic        wrapA;
   logic        enB;
   logic        seedLoadB;
   logic [3:0]  seedInB;
   logic [2:0]  levelB;
   logic        wrapB;

   int testCount = 0;
   int failCount = 0;

   logic [15:0] mState;
   logic [15:0] seen;
   int          wrapCount;
   logic [3:0]  periodTbl [16];

   lcg_rng_fifo_if #(.OUT_W(8)) busA ();
   lcg_rng_fifo_if #(.OUT_W(4)) busB ();

   always #5 clk = ~clk;

   lcg_rng_fifo #(
      .STATE_W(16), .OUT_W(8), .MULT(16'd25173), .INC(16'd13849),
      .SEED(16'd1), .DEPTH(4)
   ) dutA (
      .clk(clk), .rst(rst), .en(enA), .seed_load(seedLoadA), .seed_in(seedInA),
      .rand_bus(busA), .level(levelA), .period_wrap(wrapA)
   );

   lcg_rng_fifo #(
      .STATE_W(4), .OUT_W(4), .MULT(4'd5), .INC(4'd3), .SEED(4'd1), .DEPTH(4)
   ) dutB (
      .clk(clk), .rst(rst), .en(enB), .seed_load(seedLoadB), .seed_in(seedInB),
      .rand_bus(busB), .level(levelB), .period_wrap(wrapB)
   );

   // Reference step for the 16-bit configuration.
   function automatic logic [15:0] lcgStep(input logic [15:0] s);
      lcgStep = 16'(32'(s) * 32'd25173 + 32'd13849);
   endfunction

   // Counts one comparison and reports it if observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives every input of the 16-bit instance in one go.
   task automatic applyStimulus(input logic r, input logic e, input logic sl,
                                input logic [15:0] si, input logic rdy);
      rst              = r;
      enA              = e;
      seedLoadA        = sl;
      seedInA          = si;
      busA.rand_ready  = rdy;
   endtask

   // Advances one cycle and settles just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence.
   initial begin
      periodTbl = '{4'd3, 4'd2, 4'd13, 4'd4, 4'd7, 4'd6, 4'd1, 4'd8,
                    4'd11, 4'd10, 4'd5, 4'd12, 4'd15, 4'd14, 4'd9, 4'd0};
      enB = 1'b0; seedLoadB = 1'b0; seedInB = 4'd0; busB.rand_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      tick();
      tick();
      checkOutput("rst_level", 32'(levelA), 32'd0);
      checkOutput("rst_valid", 32'(busA.rand_valid), 32'd0);
      checkOutput("rst_out", 32'(busA.rand_out), 32'd0);
      checkOutput("rst_wrap", 32'(wrapA), 32'd0);

      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
      tick();
      checkOutput("first_valid", 32'(busA.rand_valid), 32'd1);
      checkOutput("first_word", 32'(busA.rand_out), 32'h98);
      checkOutput("first_level", 32'(levelA), 32'd1);
      tick();
      checkOutput("second_word", 32'(busA.rand_out), 32'hEE);
      checkOutput("stream_level", 32'(levelA), 32'd1);
      mState = lcgStep(lcgStep(16'd1));
      for (int i = 0; i < 998; i++) begin
         tick();
         mState = lcgStep(mState);
         checkOutput("seq_word", 32'(busA.rand_out), 32'(mState[15:8]));
      end
      checkOutput("seq_level", 32'(levelA), 32'd1);

      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput("bp_fill_level", 32'(levelA), 32'(i));
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("bp_hold_level", 32'(levelA), 32'd4);
         checkOutput("bp_hold_word", 32'(busA.rand_out), 32'h98);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
      mState = 16'd1;
      for (int k = 0; k < 8; k++) begin
         mState = lcgStep(mState);
         checkOutput("bp_drain_word", 32'(busA.rand_out), 32'(mState[15:8]));
         checkOutput("full_pop_level", 32'(levelA), 32'd4);
         tick();
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
      tick();
      checkOutput("pre_seed_level", 32'(levelA), 32'd3);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
      tick();
      checkOutput("seed_valid", 32'(busA.rand_valid), 32'd0);
      checkOutput("seed_out", 32'(busA.rand_out), 32'd0);
      checkOutput("seed_level", 32'(levelA), 32'd0);
      checkOutput("seed_wrap", 32'(wrapA), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
      tick();
      checkOutput("reseed_first", 32'(busA.rand_out), 32'h98);
      tick();
      checkOutput("reseed_second", 32'(busA.rand_out), 32'hEE);
      checkOutput("reseed_level", 32'(levelA), 32'd1);

      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
      tick();
      checkOutput("mid_level", 32'(levelA), 32'd2);
      checkOutput("mid_head", 32'(busA.rand_out), 32'hEE);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      tick();
      checkOutput("frozen_level", 32'(levelA), 32'd2);
      checkOutput("frozen_head", 32'(busA.rand_out), 32'hEE);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      tick();
      checkOutput("midrst_level", 32'(levelA), 32'd0);
      checkOutput("midrst_valid", 32'(busA.rand_valid), 32'd0);
      checkOutput("midrst_wrap", 32'(wrapA), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
      tick();
      checkOutput("midrst_restart", 32'(busA.rand_out), 32'h98);

      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      seedLoadB = 1'b1; seedInB = 4'd0; enB = 1'b1; busB.rand_ready = 1'b1;
      tick();
      checkOutput("wrap_seed_level", 32'(levelB), 32'd0);
      seedLoadB = 1'b0;
      seen      = 16'd0;
      wrapCount = 0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         checkOutput("wrap_word", 32'(busB.rand_out), 32'(periodTbl[(i - 1) % 16]));
         checkOutput("wrap_pulse", 32'(wrapB), (i % 16 == 0) ? 32'd1 : 32'd0);
         if (i <= 16) seen = seen | (16'd1 << busB.rand_out);
         if (wrapB) wrapCount++;
      end
      checkOutput("wrap_all_values", 32'(seen), 32'hFFFF);
      checkOutput("wrap_count", 32'(wrapCount), 32'd2);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
